// File: rtl/sprite_pkg.sv
// Shared constants and the per-channel configuration record for the sprite layer engine.
package sprite_pkg;

    localparam int VGA_W       = 640;
    localparam int VGA_H       = 480;

    localparam int CFG_IDX_W   = 3;
    localparam int CFG_X_W     = 11;
    localparam int CFG_Y_W     = 10;
    localparam int CFG_FRAME_W = 4;
    localparam int CFG_COLOR_W = 12;

    typedef struct packed {
        logic                   en;
        logic [CFG_X_W-1:0]     x;
        logic [CFG_Y_W-1:0]     y;
        logic [CFG_FRAME_W-1:0] frame;
        logic [CFG_COLOR_W-1:0] color;
    } sprite_cfg_t;

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: shadow/live configuration pair plus the stage-0 in-box test
// and sprite-ROM address generation.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 60,
    parameter int SPR_H      = 60,
    parameter int NUM_FRAMES = 6,
    parameter int AW         = 15,
    parameter int CW         = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en,
    input  logic                   frame_start,
    input  logic                   wr_en,
    input  logic                   cfg_en,
    input  logic [CFG_X_W-1:0]     cfg_x,
    input  logic [CFG_Y_W-1:0]     cfg_y,
    input  logic [CFG_FRAME_W-1:0] cfg_frame,
    input  logic [CW-1:0]          cfg_color,
    input  logic [9:0]             x,
    input  logic [8:0]             y,
    output logic                   inbox,
    output logic [AW-1:0]          addr,
    output logic [CW-1:0]          color
);

    localparam logic signed [11:0]      SPR_W_S      = 12'(SPR_W);
    localparam logic signed [11:0]      SPR_H_S      = 12'(SPR_H);
    localparam logic [CFG_FRAME_W-1:0]  NUM_FRAMES_F = CFG_FRAME_W'(NUM_FRAMES);

    sprite_cfg_t        shadow_r;
    sprite_cfg_t        live_r;
    logic               inbox_r;
    logic [AW-1:0]      addr_r;
    logic signed [11:0] dx_s;
    logic signed [11:0] dy_s;
    logic               inbox_s;
    logic [AW:0]        addr_full_s;

    // In-box test on 12-bit signed offsets so sprites hanging off the left/top edge clip cleanly
    always_comb begin
        dx_s        = $signed({2'b00, x}) - $signed({live_r.x[CFG_X_W-1], live_r.x});
        dy_s        = $signed({3'b000, y}) - $signed({{2{live_r.y[CFG_Y_W-1]}}, live_r.y});
        inbox_s     = live_r.en && (live_r.frame < NUM_FRAMES_F) &&
                      (dx_s >= 12'sd0) && (dx_s < SPR_W_S) &&
                      (dy_s >= 12'sd0) && (dy_s < SPR_H_S);
        addr_full_s = (AW+1)'(live_r.frame) * (AW+1)'(SPR_W * SPR_H) +
                      (AW+1)'(dy_s) * (AW+1)'(SPR_W) + (AW+1)'(dx_s);
    end

    // Shadow takes cfg writes at any clk; live reloads from the pre-write shadow at frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r <= '0;
            live_r   <= '0;
        end else begin
            if (wr_en) begin
                shadow_r <= '{en: cfg_en, x: cfg_x, y: cfg_y, frame: cfg_frame,
                              color: CFG_COLOR_W'(cfg_color)};
            end
            if (pix_en && frame_start) begin
                live_r <= shadow_r;
            end
        end
    end

    // Stage-0 pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inbox_r <= 1'b0;
            addr_r  <= '0;
        end else if (pix_en) begin
            inbox_r <= inbox_s;
            addr_r  <= inbox_s ? addr_full_s[AW-1:0] : '0;
        end
    end

    assign inbox = inbox_r;
    assign addr  = addr_r;
    assign color = CW'(live_r.color);

endmodule

// File: rtl/sprite_layer_engine.sv
// N-channel sprite compositor: fixed-priority overlay over a background colour with
// per-frame collision accumulation.
module sprite_layer_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPR    = 4,
    parameter int SPR_W      = 60,
    parameter int SPR_H      = 60,
    parameter int NUM_FRAMES = 6,
    parameter int AW         = 15,
    parameter int CW         = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en,
    input  logic                   frame_start,
    input  logic [9:0]             x,
    input  logic [8:0]             y,
    input  logic                   active,
    input  logic [CW-1:0]          bg_color,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CFG_IDX_W-1:0]   cfg_idx,
    input  logic [CFG_X_W-1:0]     cfg_x,
    input  logic [CFG_Y_W-1:0]     cfg_y,
    input  logic [CFG_FRAME_W-1:0] cfg_frame,
    input  logic [CW-1:0]          cfg_color,
    input  logic                   cfg_en,
    output logic [NUM_SPR*AW-1:0]  spr_addr,
    input  logic [NUM_SPR-1:0]     spr_bit,
    output logic [CW-1:0]          pix_out,
    output logic                   pix_valid,
    output logic [NUM_SPR-1:0]     collide_mask,
    output logic                   collide_stb
);

    logic [NUM_SPR-1:0] inbox_s;
    logic [NUM_SPR-1:0] hit_s;
    logic [NUM_SPR-1:0] coll_s;
    logic [NUM_SPR-1:0] acc_next_s;
    logic [CW-1:0]      color_s [NUM_SPR];
    logic [CW-1:0]      win_color_s;
    logic               win_found_s;

    logic [CW-1:0]      bg_d_r;
    logic               act_d_r;
    logic [CW-1:0]      pix_out_r;
    logic               pix_valid_r;
    logic [NUM_SPR-1:0] acc_r;
    logic [NUM_SPR-1:0] mask_r;
    logic               stb_r;

    // Extra bit keeps the range check correct when NUM_SPR is 8
    assign cfg_ready = ({1'b0, cfg_idx} < (CFG_IDX_W+1)'(NUM_SPR));

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_ch
        sprite_channel #(
            .SPR_W      (SPR_W),
            .SPR_H      (SPR_H),
            .NUM_FRAMES (NUM_FRAMES),
            .AW         (AW),
            .CW         (CW)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .pix_en      (pix_en),
            .frame_start (frame_start),
            .wr_en       (cfg_valid && cfg_ready && (cfg_idx == CFG_IDX_W'(i))),
            .cfg_en      (cfg_en),
            .cfg_x       (cfg_x),
            .cfg_y       (cfg_y),
            .cfg_frame   (cfg_frame),
            .cfg_color   (cfg_color),
            .x           (x),
            .y           (y),
            .inbox       (inbox_s[i]),
            .addr        (spr_addr[i*AW +: AW]),
            .color       (color_s[i])
        );
    end

    // Priority pick (descending loop so the lowest index wins) and pairwise collision terms
    always_comb begin
        hit_s       = inbox_s & spr_bit;
        win_color_s = '0;
        win_found_s = 1'b0;
        coll_s      = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            win_color_s = hit_s[i] ? color_s[i] : win_color_s;
            win_found_s = win_found_s | hit_s[i];
            coll_s[i]   = hit_s[i] & (|(hit_s & ~(NUM_SPR'(1) << i)));
        end
        acc_next_s = acc_r | (act_d_r ? coll_s : '0);
    end

    // Stage-1 compositing and collision accumulation, advancing on each pixel strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bg_d_r      <= '0;
            act_d_r     <= 1'b0;
            pix_out_r   <= '0;
            pix_valid_r <= 1'b0;
            acc_r       <= '0;
            mask_r      <= '0;
        end else if (pix_en) begin
            bg_d_r      <= bg_color;
            act_d_r     <= active;
            pix_valid_r <= act_d_r;
            pix_out_r   <= act_d_r ? (win_found_s ? win_color_s : bg_d_r) : '0;
            if (frame_start) begin
                mask_r <= acc_next_s;
                acc_r  <= '0;
            end else begin
                acc_r  <= acc_next_s;
            end
        end
    end

    // One-clk strobe marking a collision-mask update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb_r <= 1'b0;
        end else begin
            stb_r <= pix_en & frame_start;
        end
    end

    assign pix_out      = pix_out_r;
    assign pix_valid    = pix_valid_r;
    assign collide_mask = mask_r;
    assign collide_stb  = stb_r;

endmodule

// File: tb/tb_sprite_layer_engine.sv
// Directed self-checking bench for sprite_layer_engine with hand-computed expectations.
module tb_sprite_layer_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        frame_start;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        active;
    logic [11:0] bg_color;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_idx;
    logic [10:0] cfg_x;
    logic [9:0]  cfg_y;
    logic [3:0]  cfg_frame;
    logic [11:0] cfg_color;
    logic        cfg_en;
    logic [59:0] spr_addr;
    logic [3:0]  spr_bit;
    logic [11:0] pix_out;
    logic        pix_valid;
    logic [3:0]  collide_mask;
    logic        collide_stb;

    int tests_run = 0;
    int tests_failed = 0;
    int stb_count = 0;
    int stb_before;

    sprite_layer_engine dut (
        .clk          (clk),
        .reset        (reset),
        .pix_en       (pix_en),
        .frame_start  (frame_start),
        .x            (x),
        .y            (y),
        .active       (active),
        .bg_color     (bg_color),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_idx      (cfg_idx),
        .cfg_x        (cfg_x),
        .cfg_y        (cfg_y),
        .cfg_frame    (cfg_frame),
        .cfg_color    (cfg_color),
        .cfg_en       (cfg_en),
        .spr_addr     (spr_addr),
        .spr_bit      (spr_bit),
        .pix_out      (pix_out),
        .pix_valid    (pix_valid),
        .collide_mask (collide_mask),
        .collide_stb  (collide_stb)
    );

    always #5 clk = ~clk;

    // Count strobe pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (collide_stb) stb_count = stb_count + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int ch);
        return 32'(spr_addr[ch*15 +: 15]);
    endfunction

    task automatic pix(input logic [9:0] px, input logic [8:0] py, input logic act,
                       input logic [11:0] bg, input logic fs);
        @(negedge clk);
        x = px; y = py; active = act; bg_color = bg; frame_start = fs; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0; frame_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic commit();
        pix(10'd0, 9'd0, 1'b0, 12'h000, 1'b1);
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic en, input logic [10:0] cx,
                             input logic [9:0] cy, input logic [3:0] fr, input logic [11:0] col,
                             input logic exp_ready);
        @(negedge clk);
        cfg_idx = idx; cfg_en = en; cfg_x = cx; cfg_y = cy; cfg_frame = fr; cfg_color = col;
        cfg_valid = 1'b1;
        #1;
        check_val("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
        @(negedge clk);
        cfg_valid = 1'b0; cfg_idx = 3'd0;
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; frame_start = 1'b0; x = 10'd0; y = 9'd0;
        active = 1'b0; bg_color = 12'h000; cfg_valid = 1'b0; cfg_idx = 3'd0;
        cfg_x = 11'd0; cfg_y = 10'd0; cfg_frame = 4'd0; cfg_color = 12'h000; cfg_en = 1'b0;
        spr_bit = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_pix_out", 32'(pix_out), 32'h0);
        check_val("rst_pix_valid", 32'(pix_valid), 32'h0);
        check_val("rst_mask", 32'(collide_mask), 32'h0);
        check_val("rst_stb", 32'(collide_stb), 32'h0);
        check_val("rst_addr", 32'(spr_addr != 60'd0), 32'h0);
        check_val("rst_ready", 32'(cfg_ready), 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // Mid-frame write is invisible until the next commit
        cfg_write(3'd0, 1'b1, 11'd100, 10'd200, 4'd2, 12'h0F0, 1'b1);
        pix(10'd100, 9'd200, 1'b1, 12'h123, 1'b0);
        check_val("pre_commit_addr0", addr_of(0), 32'd0);
        spr_bit = 4'b0001;
        pix(10'd101, 9'd200, 1'b1, 12'h123, 1'b0);
        check_val("pre_commit_pix", 32'(pix_out), 32'h123);
        check_val("pre_commit_valid", 32'(pix_valid), 32'h1);
        stb_before = stb_count;
        commit();
        check_val("stb_first_frame", 32'(stb_count - stb_before), 32'd1);
        check_val("mask_first_frame", 32'(collide_mask), 32'h0);
        pix(10'd100, 9'd200, 1'b1, 12'h123, 1'b0);
        check_val("commit_addr0", addr_of(0), 32'd7200);
        pix(10'd101, 9'd200, 1'b1, 12'h123, 1'b0);
        check_val("commit_pix", 32'(pix_out), 32'h0F0);
        check_val("commit_addr0_next", addr_of(0), 32'd7201);

        // Overlap of ch0 and ch1: priority and collision
        cfg_write(3'd0, 1'b1, 11'd300, 10'd250, 4'd0, 12'h00F, 1'b1);
        cfg_write(3'd1, 1'b1, 11'd300, 10'd250, 4'd0, 12'hF00, 1'b1);
        spr_bit = 4'b0000;
        commit();
        check_val("mask_solo_frame", 32'(collide_mask), 32'h0);
        pix(10'd310, 9'd252, 1'b1, 12'h123, 1'b0);
        check_val("overlap_addr0", addr_of(0), 32'd130);
        check_val("overlap_addr1", addr_of(1), 32'd130);
        spr_bit = 4'b0011;
        pix(10'd311, 9'd252, 1'b1, 12'h123, 1'b0);
        check_val("priority_ch0", 32'(pix_out), 32'h00F);
        spr_bit = 4'b0010;
        pix(10'd312, 9'd252, 1'b1, 12'h123, 1'b0);
        check_val("priority_ch1_only", 32'(pix_out), 32'hF00);
        spr_bit = 4'b0000;
        stb_before = stb_count;
        commit();
        check_val("collide_mask", 32'(collide_mask), 32'h3);
        check_val("collide_stb_once", 32'(stb_count - stb_before), 32'd1);
        check_val("collide_stb_low", 32'(collide_stb), 32'h0);
        spr_bit = 4'b0001;
        pix(10'd310, 9'd252, 1'b1, 12'h123, 1'b0);
        pix(10'd311, 9'd252, 1'b1, 12'h123, 1'b0);
        check_val("solo_hit_pix", 32'(pix_out), 32'h00F);
        spr_bit = 4'b0000;
        commit();
        check_val("no_overlap_mask", 32'(collide_mask), 32'h0);

        // Left-edge clipping with x=-20
        cfg_write(3'd2, 1'b1, 11'h7EC, 10'd0, 4'd1, 12'hABC, 1'b1);
        commit();
        pix(10'd0, 9'd10, 1'b1, 12'h123, 1'b0);
        check_val("clip_addr_x0", addr_of(2), 32'd4220);
        spr_bit = 4'b0100;
        pix(10'd39, 9'd10, 1'b1, 12'h123, 1'b0);
        check_val("clip_pix_x0", 32'(pix_out), 32'hABC);
        check_val("clip_addr_x39", addr_of(2), 32'd4259);
        pix(10'd40, 9'd10, 1'b1, 12'h123, 1'b0);
        check_val("clip_addr_x40", addr_of(2), 32'd0);
        check_val("clip_pix_x39", 32'(pix_out), 32'hABC);
        pix(10'd41, 9'd10, 1'b1, 12'h123, 1'b0);
        check_val("clip_pix_x40", 32'(pix_out), 32'h123);

        // Out-of-range index and out-of-range frame
        cfg_write(3'd3, 1'b1, 11'd500, 10'd400, 4'd6, 12'h333, 1'b1);
        cfg_write(3'd7, 1'b1, 11'd500, 10'd400, 4'd0, 12'h777, 1'b0);
        spr_bit = 4'b0000;
        commit();
        pix(10'd505, 9'd405, 1'b1, 12'h5A5, 1'b0);
        check_val("bad_frame_addr3", addr_of(3), 32'd0);
        spr_bit = 4'b1111;
        pix(10'd506, 9'd405, 1'b1, 12'h5A5, 1'b0);
        check_val("bad_frame_pix", 32'(pix_out), 32'h5A5);

        // Asynchronous reset mid-frame
        spr_bit = 4'b0100;
        pix(10'd0, 9'd10, 1'b1, 12'h123, 1'b0);
        pix(10'd1, 9'd10, 1'b1, 12'h123, 1'b0);
        check_val("pre_reset_pix", 32'(pix_out), 32'hABC);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("mid_rst_pix_out", 32'(pix_out), 32'h0);
        check_val("mid_rst_valid", 32'(pix_valid), 32'h0);
        check_val("mid_rst_addr", 32'(spr_addr != 60'd0), 32'h0);
        check_val("mid_rst_mask", 32'(collide_mask), 32'h0);
        check_val("mid_rst_stb", 32'(collide_stb), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        pix(10'd0, 9'd10, 1'b1, 12'h000, 1'b0);
        check_val("post_rst_addr2", addr_of(2), 32'd0);
        pix(10'd1, 9'd10, 1'b1, 12'h000, 1'b0);
        check_val("post_rst_pix", 32'(pix_out), 32'h0);
        check_val("post_rst_valid", 32'(pix_valid), 32'h1);
        commit();
        pix(10'd0, 9'd10, 1'b1, 12'h000, 1'b0);
        pix(10'd1, 9'd10, 1'b1, 12'h000, 1'b0);
        check_val("post_rst_commit_pix", 32'(pix_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sprite_layer_engine.md
Name: sprite_layer_engine

Overview:
- Parametrised N-channel sprite compositor for the 640x480 VGA path; generalises the fixed per-object sprite logic (dino, cacti, clouds, digits) into uniform channels.
- Each channel has double-buffered position, frame, colour and enable registers that commit at frame boundary.
- Per pixel it generates sprite-ROM addresses, composites by fixed priority over a background colour, and accumulates a per-channel collision mask each frame.
- Sits between VGATimingGenerator and the RGB output; sprite ROMs stay outside the block.

Parameters:
- NUM_SPR, 4, number of sprite channels (1..8).
- SPR_W, 60, sprite width in pixels.
- SPR_H, 60, sprite height in pixels.
- NUM_FRAMES, 6, frames per sprite ROM.
- AW, 15, sprite ROM address width; must satisfy NUM_FRAMES*SPR_W*SPR_H <= 2^AW.
- CW, 12, colour width.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high.
- pix_en  in  1  one-clk pixel strobe at 25 MHz; all pixel-pipeline state advances only when high.
- frame_start  in  1  one-pixel pulse between frames (screenEnd), sampled with pix_en.
- x  in  10  current pixel column.
- y  in  9  current pixel row.
- active  in  1  visible-region flag.
- bg_color  in  CW  background colour for the current pixel.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when valid&ready.
- cfg_idx  in  3  channel index.
- cfg_x  in  11  signed sprite left edge.
- cfg_y  in  10  signed sprite top edge.
- cfg_frame  in  4  frame select.
- cfg_color  in  CW  opaque-pixel colour.
- cfg_en  in  1  channel enable.
- spr_addr  out  NUM_SPR*AW  flat ROM addresses; channel i occupies [i*AW +: AW].
- spr_bit  in  NUM_SPR  ROM opacity bits; valid one pix_en after the address.
- pix_out  out  CW  composited colour.
- pix_valid  out  1  registered active, aligned with pix_out.
- collide_mask  out  NUM_SPR  per-channel collision flags for the last complete frame.
- collide_stb  out  1  one-clk pulse when collide_mask updates.

Behaviour:
- Reset values:
  - All shadow and live registers are 0, so every channel is disabled.
  - pix_out=0, pix_valid=0, collide_mask=0, collide_stb=0, spr_addr=0, cfg_ready=1.
- Config handshake:
  - cfg_ready is 1 at all times except when cfg_idx>=NUM_SPR.
  - A transfer (valid&ready on any clk edge) writes the shadow set of channel cfg_idx.
  - An out-of-range cfg_idx holds cfg_ready low and writes nothing.
- Commit:
  - On pix_en&frame_start, every live set is loaded from its shadow set.
  - A cfg transfer in the same clk lands in the shadow only. The commit uses the pre-write shadow value; the new value is live from the next frame.
- Stage 0, registered on pix_en:
  - Per channel, inbox_i = en & frame<NUM_FRAMES & sx<=x<sx+SPR_W & sy<=y<sy+SPR_H. Compare signed at 12 bits, so partially off-screen sprites clip correctly.
  - When inbox_i, spr_addr_i = frame*SPR_W*SPR_H + (y-sy)*SPR_W + (x-sx); otherwise spr_addr_i = 0.
  - inbox, bg_color and active are delayed alongside.
- Stage 1, registered on pix_en:
  - hit_i = inbox_i & spr_bit_i.
  - pix_out = colour of the lowest-index hit channel, else delayed bg_color; it is forced to 0 when the delayed active is 0.
  - pix_valid = delayed active.
  - Latency is 2 pix_en strobes from x/y to pix_out.
- Collision:
  - Accumulator acc_i |= hit_i & (any hit_j, j!=i), updated on each stage-1 strobe while active.
  - On pix_en&frame_start: collide_mask <= acc (including that strobe's contribution), acc <= 0, collide_stb=1 for one clk.
- Disabled channels and channels with an out-of-range frame never draw and never collide.
- Asynchronous reset mid-frame clears everything immediately. Output stays 0 until the next frame_start commits new config.
- Arithmetic: multiplies by constant parameters only; intermediates are widened to AW+1 before truncation.

Decomposition:
- Package sprite_pkg holds:
  - the VGA_W/VGA_H constants;
  - the cfg field widths;
  - a sprite_cfg_t struct {en, x, y, frame, color}.
- Sub-module sprite_channel, instanced NUM_SPR times:
  - holds the shadow/live register pair;
  - performs the stage-0 in-box test and address computation.
- Compositing and collision logic stay in the top.

Test Plan:
- Config/commit:
  - Stimulus: write ch0 {en=1,x=100,y=200,frame=2,color=h0F0} mid-frame; drive x=100,y=200.
  - Required: no effect until the next frame_start. Next frame at x=100,y=200: spr_addr0=7200. With spr_bit0=1, pix_out=h0F0 two strobes later.
- Priority:
  - Stimulus: ch0 and ch1 overlap at (300,250), both bits 1, colours h00F and hF00.
  - Required: pix_out=h00F; ch0 wins.
- Collision:
  - Stimulus: same overlap as the priority test, held for one frame.
  - Required: at frame_start, collide_mask=b0011 and collide_stb pulses once. Next frame with no overlap: mask=b0000.
- Clipping:
  - Stimulus: ch2 with x=-20.
  - Required: at pixel x=0 inbox2=1 and spr_addr2 column offset is 20. At pixel x=40, inbox2=0.
- Boundaries:
  - Stimulus: cfg_idx=7 with NUM_SPR=4; separately frame=6 with NUM_FRAMES=6.
  - Required: idx 7 holds cfg_ready=0 and writes nothing. frame=6 never draws; pix_out=bg_color.
- Reset:
  - Stimulus: assert reset mid-frame.
  - Required: all outputs 0 immediately. After release, pix_out=0 in the active region until config is written and committed.
